// File: rtl/multiplicador_4b.sv
// Sequential shift-and-add multiplier: product = quotient*denominator + rest.
// Optional MULTIPLICADOR_4B_OVF_EN adds an ovf flag for products wider than WIDTH bits.
module multiplicador_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   denominator,
  input  logic [WIDTH-1:0]   rest,
  output logic [2*WIDTH-1:0] product,
`ifdef MULTIPLICADOR_4B_OVF_EN
  output logic               ovf,
`endif
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_addend;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    w_sum;

  // Final reconstruction: accumulated partial products plus the remainder.
  assign w_sum = r_acc + PW'(r_addend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_addend <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      product  <= '0;
`ifdef MULTIPLICADOR_4B_OVF_EN
      ovf      <= 1'b0;
`endif
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= PW'(quotient);
            r_mplier <= denominator;
            r_addend <= rest;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          product <= w_sum;
`ifdef MULTIPLICADOR_4B_OVF_EN
          ovf     <= |w_sum[PW-1:WIDTH];
`endif
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_4b.sv
// Directed self-checking bench for multiplicador_4b (define MULTIPLICADOR_4B_OVF_EN to check ovf).
module tb_multiplicador_4b;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] quotient;
  logic [3:0] denominator;
  logic [3:0] rest;
  logic [7:0] product;
  logic       busy;
  logic       done;
`ifdef MULTIPLICADOR_4B_OVF_EN
  logic       ovf;
`endif

  int total = 0;
  int bad   = 0;

  multiplicador_4b #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .quotient    (quotient),
    .denominator (denominator),
    .rest        (rest),
    .product     (product),
`ifdef MULTIPLICADOR_4B_OVF_EN
    .ovf         (ovf),
`endif
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation: checks busy, latency to done, product, and that inputs are captured once.
  task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] d,
                        input logic [3:0] r, input logic [7:0] exp);
    int n;
    @(negedge clk);
    quotient = q; denominator = d; rest = r; start = 1'b1;
    step();
    start = 1'b0;
    quotient = ~q; denominator = ~d; rest = ~r;
    chk({tag, "_busy1"}, 32'(busy), 32'd1);
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd6);
    chk({tag, "_product"}, 32'(product), 32'(exp));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef MULTIPLICADOR_4B_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), (exp > 8'd15) ? 32'd1 : 32'd0);
`endif
    step();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0;
    quotient = '0; denominator = '0; rest = '0;
    #1;
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("op_7x2p1", 4'd7, 4'd2, 4'd1, 8'd15);
    run_op("op_15x15p15", 4'd15, 4'd15, 4'd15, 8'd240);
    run_op("op_9x0p5", 4'd9, 4'd0, 4'd5, 8'd5);
    run_op("op_0x6p0", 4'd0, 4'd6, 4'd0, 8'd0);

    // start re-asserted mid-operation must be ignored
    @(negedge clk);
    quotient = 4'd3; denominator = 4'd3; rest = 4'd0; start = 1'b1;
    step();
    start = 1'b0;
    pulses = 0;
    for (int i = 2; i <= 15; i++) begin
      if (i == 3) begin
        @(negedge clk);
        quotient = 4'd15; denominator = 4'd15; rest = 4'd15; start = 1'b1;
        step();
        @(negedge clk);
        start = 1'b0;
      end else begin
        step();
      end
      if (done) begin
        pulses++;
        chk("ign_edge", 32'(i), 32'd6);
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);
    chk("ign_product", 32'(product), 32'd9);

    // asynchronous reset mid-operation
    @(negedge clk);
    quotient = 4'd5; denominator = 4'd3; rest = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_product", 32'(product), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) pulses++;
    end
    chk("arst_no_done", 32'(pulses), 32'd0);
    run_op("op_5x3p2", 4'd5, 4'd3, 4'd2, 8'd17);

    // start held high: one operation per 7 cycles
    @(negedge clk);
    quotient = 4'd4; denominator = 4'd2; rest = 4'd1; start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 21; i++) begin
      step();
      if (done) begin
        chk("held_edge", 32'(i), 32'(6 + 7 * pulses));
        chk("held_product", 32'(product), 32'd9);
        pulses++;
      end
    end
    chk("held_pulses", 32'(pulses), 32'd3);
    @(negedge clk);
    start = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
